// File: rtl/memoria_ud_pkg.sv
// memoria_ud_pkg: shared types and constants for the memoria_ud bus responder.
// Holds the access FSM state enum, default geometry and the zero data word.
package memoria_ud_pkg;

    typedef enum logic [1:0] {
        INACTIVO,
        ESPERA,
        ACK
    } estado_t;

    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_BITS_DEF = 8;

    localparam logic [DATA_W_DEF-1:0] CERO = '0;

endpackage

// File: rtl/contador_espera.sv
// contador_espera: 4-bit wait-state down-counter with load and terminal count.
// Ports: clk, rst (sync, active-high), carga/valor load, habilita count
// enable, fin high when the current wait cycle is the last one.
module contador_espera (
    input  logic       clk,
    input  logic       rst,
    input  logic       carga,
    input  logic       habilita,
    input  logic [3:0] valor,
    output logic       fin
);

    logic [3:0] cuenta;

    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta <= '0;
        end else if (carga) begin
            cuenta <= valor;
        end else if (habilita && cuenta != 4'd0) begin
            cuenta <= cuenta - 4'd1;
        end
    end

    // Loaded with N on acceptance: fin rises in the Nth wait cycle.
    assign fin = (cuenta <= 4'd1);

endmodule

// File: rtl/memoria_ud.sv
// memoria_ud: word-addressed memory answering a four-phase Leer/Escribir
// handshake with programmable wait states.
// Ports: clk, rst (sync, active-high); Direcciones, DatosIn, Leer, Escribir
// from the CPU; DatosOut/oeMem to the bus buffer, Listo ack, ErrorDir reject.
module memoria_ud
    import memoria_ud_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_BITS   = ADDR_BITS_DEF,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       Direcciones,
    input  logic [DATA_W-1:0] DatosIn,
    input  logic              Leer,
    input  logic              Escribir,
    output logic [DATA_W-1:0] DatosOut,
    output logic              oeMem,
    output logic              Listo,
    output logic              ErrorDir
);

    localparam logic [3:0] ESPERAS = 4'(WAIT_STATES);
    localparam int         PROF    = 1 << ADDR_BITS;

    estado_t estado;
    estado_t estado_sig;

    logic [ADDR_BITS-1:0] lat_addr;
    logic [DATA_W-1:0]    lat_dato;
    logic                 lat_lect;
    logic                 lat_escr;
    logic                 lat_err;

    logic [DATA_W-1:0] mem [PROF];

    logic                 strobe_any;
    logic                 ambos;
    logic                 fuera;
    logic                 strobe_op;
    logic                 acepta;
    logic                 fin;
    logic                 escribe;
    logic                 sostiene;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_W-1:0]    wr_dato;

    assign strobe_any = Leer | Escribir;
    assign ambos      = Leer & Escribir;
    assign fuera      = |Direcciones[15:ADDR_BITS];
    assign strobe_op  = lat_lect ? Leer : Escribir;
    assign acepta     = (estado == INACTIVO) && strobe_any;
    assign sostiene   = (estado == ACK) && strobe_any;

    contador_espera u_espera (
        .clk      (clk),
        .rst      (rst),
        .carga    (acepta),
        .habilita (estado == ESPERA),
        .valor    (ESPERAS),
        .fin      (fin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= INACTIVO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        unique case (estado)
            INACTIVO: begin
                if (ambos) begin
                    estado_sig = ACK;
                end else if (strobe_any) begin
                    estado_sig = (ESPERAS == 4'd0) ? ACK : ESPERA;
                end
            end
            ESPERA: begin
                // Dropping the accepted strobe early aborts the access.
                if (!strobe_op) begin
                    estado_sig = INACTIVO;
                end else if (fin) begin
                    estado_sig = ACK;
                end
            end
            ACK: begin
                if (!strobe_any) begin
                    estado_sig = INACTIVO;
                end
            end
            default: estado_sig = INACTIVO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr <= '0;
            lat_dato <= '0;
            lat_lect <= 1'b0;
            lat_escr <= 1'b0;
            lat_err  <= 1'b0;
        end else if (acepta) begin
            lat_addr <= Direcciones[ADDR_BITS-1:0];
            lat_dato <= DatosIn;
            lat_lect <= Leer & ~Escribir;
            lat_escr <= Escribir & ~Leer;
            lat_err  <= fuera | ambos;
        end
    end

    // Commit on the edge entering ACK. With no wait states that edge is
    // the acceptance edge itself, so the live bus is used instead.
    always_comb begin
        escribe = 1'b0;
        wr_addr = lat_addr;
        wr_dato = lat_dato;
        if (estado == INACTIVO) begin
            wr_addr = Direcciones[ADDR_BITS-1:0];
            wr_dato = DatosIn;
            escribe = (ESPERAS == 4'd0) && Escribir
                   && !Leer && !fuera;
        end else if (estado == ESPERA) begin
            escribe = fin && lat_escr && Escribir && !lat_err;
        end
        if (rst) begin
            escribe = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (escribe) begin
            mem[wr_addr] <= wr_dato;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Listo    <= 1'b0;
            ErrorDir <= 1'b0;
            oeMem    <= 1'b0;
            DatosOut <= DATA_W'(CERO);
        end else begin
            Listo    <= sostiene;
            ErrorDir <= sostiene && lat_err;
            oeMem    <= sostiene && lat_lect;
            if (sostiene && lat_lect && !lat_err) begin
                DatosOut <= mem[lat_addr];
            end else begin
                DatosOut <= DATA_W'(CERO);
            end
        end
    end

endmodule

// File: tb/tb_memoria_ud.sv
// tb_memoria_ud: scoreboard bench for memoria_ud, one instance with two
// wait states and one with none.
module tb_memoria_ud;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
        logic        o;
    } esp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dir  [2];
    logic [15:0] din  [2];
    logic        leer [2];
    logic        escr [2];
    logic [15:0] dout [2];
    logic        oe   [2];
    logic        listo[2];
    logic        err  [2];

    esp_t cola[$];
    int   checks  = 0;
    int   errores = 0;

    always #5 clk = ~clk;

    memoria_ud #(.DATA_W(16), .ADDR_BITS(8), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .Direcciones(dir[0]), .DatosIn(din[0]),
        .Leer(leer[0]), .Escribir(escr[0]),
        .DatosOut(dout[0]), .oeMem(oe[0]),
        .Listo(listo[0]), .ErrorDir(err[0])
    );

    memoria_ud #(.DATA_W(16), .ADDR_BITS(8), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .Direcciones(dir[1]), .DatosIn(din[1]),
        .Leer(leer[1]), .Escribir(escr[1]),
        .DatosOut(dout[1]), .oeMem(oe[1]),
        .Listo(listo[1]), .ErrorDir(err[1])
    );

    task automatic chequear(input string tag,
                            input logic [31:0] obs,
                            input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Called at a negedge. Raises the strobes, waits for Listo, checks
    // the popped expectation, releases and checks the return to idle.
    task automatic acceso(input int d, input bit lee, input bit es,
                          input logic [15:0] a, input logic [15:0] dato,
                          input logic [15:0] exp_d, input bit exp_e,
                          input bit exp_o, input int lat,
                          input bit hold, input string tag,
                          output int per);
        int   n;
        esp_t e;
        cola.push_back('{exp_d, exp_e, exp_o});
        dir[d]  = a;
        din[d]  = dato;
        leer[d] = lee;
        escr[d] = es;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!listo[d] && n < 40);
        e = cola.pop_front();
        chequear({tag, "_listo"}, 32'(listo[d]), 32'd1);
        chequear({tag, "_lat"}, n - 1, lat);
        chequear({tag, "_dato"}, 32'(dout[d]), 32'(e.d));
        chequear({tag, "_err"}, 32'(err[d]), 32'(e.e));
        chequear({tag, "_oe"}, 32'(oe[d]), 32'(e.o));
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            chequear({tag, "_hold_listo"}, 32'(listo[d]), 32'd1);
            chequear({tag, "_hold_dato"}, 32'(dout[d]), 32'(e.d));
        end
        leer[d] = 1'b0;
        escr[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chequear({tag, "_rel_listo"}, 32'(listo[d]), 32'd0);
        chequear({tag, "_rel_oe"}, 32'(oe[d]), 32'd0);
        chequear({tag, "_rel_dato"}, 32'(dout[d]), 32'd0);
        per = n + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        for (int i = 0; i < 2; i++) begin
            dir[i]  = '0;
            din[i]  = '0;
            leer[i] = 1'b0;
            escr[i] = 1'b0;
        end
        // Out-of-range read held through reset.
        dir[0]  = 16'h0100;
        leer[0] = 1'b1;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chequear("rst_listo", 32'(listo[i]), 32'd0);
            chequear("rst_oe", 32'(oe[i]), 32'd0);
            chequear("rst_err", 32'(err[i]), 32'd0);
            chequear("rst_dato", 32'(dout[i]), 32'd0);
        end
        rst = 1'b0;
        acceso(0, 1, 0, 16'h0100, 16'h0, 16'h0, 1, 1, 3, 0,
               "rst_read", p);

        acceso(0, 0, 1, 16'h0012, 16'hBEEF, 16'h0, 0, 0, 3, 0,
               "wr_12", p);
        acceso(0, 1, 0, 16'h0012, 16'h0, 16'hBEEF, 0, 1, 3, 1,
               "rd_12", p);

        acceso(0, 0, 1, 16'h0000, 16'h1111, 16'h0, 0, 0, 3, 0,
               "wr_00", p);
        acceso(0, 0, 1, 16'h0100, 16'h1234, 16'h0, 1, 0, 3, 0,
               "wr_oor", p);
        acceso(0, 1, 0, 16'h0100, 16'h0, 16'h0, 1, 1, 3, 0,
               "rd_oor", p);
        acceso(0, 1, 0, 16'h0000, 16'h0, 16'h1111, 0, 1, 3, 0,
               "rd_00", p);

        acceso(0, 0, 1, 16'h0005, 16'h5A5A, 16'h0, 0, 0, 3, 0,
               "wr_05", p);
        acceso(0, 1, 1, 16'h0005, 16'hFFFF, 16'h0, 1, 0, 1, 0,
               "both_05", p);
        acceso(0, 1, 0, 16'h0005, 16'h0, 16'h5A5A, 0, 1, 3, 0,
               "rd_05", p);

        // Write aborted after one wait cycle.
        acceso(0, 0, 1, 16'h0003, 16'h3333, 16'h0, 0, 0, 3, 0,
               "wr_03", p);
        dir[0]  = 16'h0003;
        din[0]  = 16'hAAAA;
        escr[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 escr[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chequear("abort_listo", 32'(listo[0]), 32'd0);
        end
        acceso(0, 1, 0, 16'h0003, 16'h0, 16'h3333, 0, 1, 3, 0,
               "rd_03", p);

        // Reset on the edge that would have committed the write.
        acceso(0, 0, 1, 16'h0007, 16'h7777, 16'h0, 0, 0, 3, 0,
               "wr_07", p);
        dir[0]  = 16'h0007;
        din[0]  = 16'h5555;
        escr[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        escr[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chequear("rstmid_listo", 32'(listo[0]), 32'd0);
        chequear("rstmid_dato", 32'(dout[0]), 32'd0);
        chequear("rstmid_oe", 32'(oe[0]), 32'd0);
        rst = 1'b0;
        acceso(0, 1, 0, 16'h0007, 16'h0, 16'h7777, 0, 1, 3, 0,
               "rd_07", p);

        // No wait states: back-to-back accesses, 3 cycles each.
        acceso(1, 0, 1, 16'h0009, 16'h0909, 16'h0, 0, 0, 1, 0,
               "z_wr1", p);
        chequear("z_wr1_per", p, 3);
        acceso(1, 1, 0, 16'h0009, 16'h0, 16'h0909, 0, 1, 1, 0,
               "z_rd1", p);
        chequear("z_rd1_per", p, 3);
        acceso(1, 0, 1, 16'h0009, 16'h9090, 16'h0, 0, 0, 1, 0,
               "z_wr2", p);
        chequear("z_wr2_per", p, 3);
        acceso(1, 1, 0, 16'h0009, 16'h0, 16'h9090, 0, 1, 1, 0,
               "z_rd2", p);
        chequear("z_rd2_per", p, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errores);
        $finish;
    end

endmodule
